// File: rtl/qbert_pkg.sv
// Shared Q*bert types: jump command encoding (also used by the sprite layer),
// controller FSM states and pyramid geometry helpers.
package qbert_pkg;

  localparam int unsigned NROWS = 7;

  typedef enum logic [2:0] {
    JUMP_NONE = 3'b000,
    JUMP_DR   = 3'b001,
    JUMP_DL   = 3'b010,
    JUMP_UR   = 3'b011,
    JUMP_UL   = 3'b100
  } jump_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_MOVING,
    ST_LAND,
    ST_OVER
  } state_t;

  function automatic logic jump_is_bad(input jump_t j, input logic [2:0] row,
                                       input logic [2:0] col, input logic [2:0] last_row);
    logic bad;
    bad = 1'b0;
    case (j)
      JUMP_DR, JUMP_DL: bad = (row == last_row);
      JUMP_UR:          bad = (row == 3'd0) || (col == row);
      JUMP_UL:          bad = (row == 3'd0) || (col == 3'd0);
      default:          bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Returns {row, col} of the destination cube; only meaningful for a valid jump.
  function automatic logic [5:0] jump_target(input jump_t j, input logic [2:0] row,
                                             input logic [2:0] col);
    logic [5:0] tgt;
    tgt = {row, col};
    case (j)
      JUMP_DR: tgt = {row + 3'd1, col + 3'd1};
      JUMP_DL: tgt = {row + 3'd1, col};
      JUMP_UR: tgt = {row - 3'd1, col};
      JUMP_UL: tgt = {row - 3'd1, col - 3'd1};
      default: tgt = {row, col};
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stable-level counter, rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_d;
  logic [CW-1:0] r_cnt;

  // The synchronised level must differ from the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles before it is taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_stable & ~r_stable_d;

endmodule

// File: rtl/qbert_jump_ctrl.sv
// Q*bert jump controller: turns debounced button presses into jump commands,
// runs the sprite-layer move handshake, tracks cube position and lives.
module qbert_jump_ctrl #(
  parameter int unsigned NROWS           = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LIVES           = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nios_start_qbert,
  input  logic [3:0] btn_dir,
  input  logic       done_move,
  output logic [2:0] qbert_jump,
  output logic       bad_jump,
  output logic [2:0] cube_row,
  output logic [2:0] cube_col,
  output logic       cube_hit,
  output logic [1:0] lives,
  output logic       game_over
);

  import qbert_pkg::*;

  localparam logic [2:0] LAST_ROW   = 3'(NROWS - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t     r_state, w_state_nxt;
  jump_t      r_jump, w_jump_nxt;
  logic       r_bad, w_bad_nxt;
  logic [2:0] r_row, w_row_nxt;
  logic [2:0] r_col, w_col_nxt;
  logic       r_hit, w_hit_nxt;
  logic [1:0] r_lives, w_lives_nxt;
  logic       w_restart;
  logic [3:0] w_press;
  jump_t      w_req;
  logic [5:0] w_tgt;

  assign w_restart = reset | nios_start_qbert;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk  (clk),
      .i_rst  (w_restart),
      .i_btn  (btn_dir[g]),
      .o_press(w_press[g])
    );
  end

  // Anything other than exactly one press event maps to no request.
  always_comb begin
    w_req = JUMP_NONE;
    case (w_press)
      4'b0001: w_req = JUMP_DR;
      4'b0010: w_req = JUMP_DL;
      4'b0100: w_req = JUMP_UR;
      4'b1000: w_req = JUMP_UL;
      default: w_req = JUMP_NONE;
    endcase
  end

  assign w_tgt = jump_target(r_jump, r_row, r_col);

  always_comb begin
    w_state_nxt = r_state;
    w_jump_nxt  = r_jump;
    w_bad_nxt   = r_bad;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_hit_nxt   = 1'b0;
    w_lives_nxt = r_lives;
    case (r_state)
      ST_IDLE: begin
        if (w_req != JUMP_NONE) begin
          w_jump_nxt  = w_req;
          w_bad_nxt   = jump_is_bad(w_req, r_row, r_col, LAST_ROW);
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!done_move) w_state_nxt = ST_MOVING;
      end
      ST_MOVING: begin
        // Landing is committed on the edge into LAND so that position, lives
        // and the hit pulse are already visible while the FSM sits in LAND.
        if (done_move) begin
          w_state_nxt = ST_LAND;
          w_jump_nxt  = JUMP_NONE;
          w_bad_nxt   = 1'b0;
          if (r_bad) begin
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_lives_nxt = (r_lives == '0) ? '0 : r_lives - 2'd1;
          end else begin
            w_row_nxt = w_tgt[5:3];
            w_col_nxt = w_tgt[2:0];
            w_hit_nxt = 1'b1;
          end
        end
      end
      ST_LAND: w_state_nxt = (r_lives == '0) ? ST_OVER : ST_IDLE;
      ST_OVER: w_state_nxt = ST_OVER;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_state <= ST_IDLE;
      r_jump  <= JUMP_NONE;
      r_bad   <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_hit   <= 1'b0;
      r_lives <= LIVES_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_jump  <= w_jump_nxt;
      r_bad   <= w_bad_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_hit   <= w_hit_nxt;
      r_lives <= w_lives_nxt;
    end
  end

  assign qbert_jump = r_jump;
  assign bad_jump   = r_bad;
  assign cube_row   = r_row;
  assign cube_col   = r_col;
  assign cube_hit   = r_hit;
  assign lives      = r_lives;
  assign game_over  = (r_state == ST_OVER);

endmodule

// File: doc/qbert_jump_ctrl.md
# qbert_jump_ctrl

Converts the four raw direction buttons into single, validated jump commands for the Q*bert sprite layer. It tracks Q*bert's logical cube position on the 7-row, 28-cube pyramid and flags jumps that leave the pyramid. It also runs the move handshake with the sprite layer and manages lives. It sits directly upstream of the sprite layer: it drives that layer's `qbert_jump` and `bad_jump` inputs and consumes its `done_move` output.

## Interface
- `NROWS`, 7: pyramid rows; row r holds cubes col 0..r.
- `DEBOUNCE_CYCLES`, 500000: cycles a synchronised button level must stay stable before it is accepted.
- `LIVES`, 3: lives loaded at reset/start.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `nios_start_qbert` in 1: level; restarts the game (position, lives, FSM).
- `btn_dir` in 4: raw, asynchronous, active-high buttons {UP_LEFT, UP_RIGHT, DOWN_LEFT, DOWN_RIGHT} (bit 3..0).
- `done_move` in 1: sprite-layer move status; low while moving, high when idle.
- `qbert_jump` out 3: 000 none, 001 DOWN_RIGHT, 010 DOWN_LEFT, 011 UP_RIGHT, 100 UP_LEFT.
- `bad_jump` out 1: current jump leaves the pyramid.
- `cube_row` out 3: current row.
- `cube_col` out 3: current column.
- `cube_hit` out 1: 1-cycle pulse on valid landing.
- `lives` out 2: remaining lives.
- `game_over` out 1: lives exhausted.

## Operation
- Buttons: each bit passes a 2-FF synchroniser, then the debouncer. A press event is a debounced 0→1 edge. Press events are acted on only in IDLE; in any other state they are dropped. If more than one press event occurs in the same cycle, all are ignored.
- FSM states: IDLE, ISSUE, MOVING, LAND, OVER.
  - IDLE: on a single press event, latch the direction into `qbert_jump`, compute `bad_jump`, and go to ISSUE.
  - ISSUE: hold `qbert_jump` and `bad_jump`; when `done_move`=0, go to MOVING.
  - MOVING: hold `qbert_jump` and `bad_jump`; when `done_move`=1, go to LAND.
  - LAND: clear `qbert_jump` to 000 and `bad_jump` to 0; update position and lives; go to OVER if `lives` has reached 0, otherwise IDLE.
  - OVER: `game_over`=1; all buttons ignored until restart.
- Target cell (r = row, c = col):
  - DOWN_LEFT → (r+1, c)
  - DOWN_RIGHT → (r+1, c+1)
  - UP_RIGHT → (r−1, c)
  - UP_LEFT → (r−1, c−1)
- Bad jump when any of:
  - a down move with r = NROWS−1
  - any up move with r = 0
  - UP_LEFT with c = 0
  - UP_RIGHT with c = r
- Landing, valid jump: position ← target; `cube_hit` pulses.
- Landing, bad jump: position ← (0,0); `lives` decrements; no `cube_hit`.
- `lives` saturates at 0.
- Position arithmetic is 3-bit unsigned. A target is never written unless it is valid.
- `nios_start_qbert` (any state, including mid-move): same effect as reset on the next edge, and takes priority over every other event.

## Timing
- Reset values:
  - `qbert_jump` 000, `bad_jump` 0
  - `cube_row` 0, `cube_col` 0
  - `cube_hit` 0, `lives` = LIVES, `game_over` 0
  - FSM in IDLE; debouncer counters and stable levels 0
- Latency from button to command: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle. `qbert_jump` becomes valid the cycle after the press event.
- `qbert_jump` and `bad_jump` change only on entry to ISSUE and in LAND. They are stable for the whole handshake.
- Position, `lives` and the `cube_hit` pulse all update in the cycle the FSM is in LAND, i.e. one cycle after `done_move` rises.
- `game_over` rises in the cycle after LAND when the final life is lost.
- `done_move` held high forever leaves the FSM in ISSUE. This is legal; there is no timeout. Reset or restart recovers.
- A press event arriving in the same cycle as the LAND→IDLE transition is dropped.

## Structure
- Shared package `qbert_pkg`:
  - `jump_t` enum with the 3-bit encodings above (shared with the sprite layer)
  - `NROWS` constant
  - FSM state typedef
- One sub-module, `btn_debounce` (sync + stable counter + edge detect, 1 bit), instantiated 4×.
- Everything else stays in `qbert_jump_ctrl`.

## Test plan
- Reset, then DOWN_RIGHT press with DEBOUNCE_CYCLES=4; model `done_move` 1→0 for 10 cycles →1 → `qbert_jump`=001 and `bad_jump`=0 during the handshake; LAND gives row 1, col 1, one `cube_hit` pulse, `qbert_jump`=000.
- At (0,0), press UP_LEFT → `bad_jump`=1 with `qbert_jump`=100; after the handshake, position (0,0), `lives` 3→2, no `cube_hit`.
- Three consecutive bad jumps → `lives` reaches 0 and `game_over`=1; a further press gives no `qbert_jump`; `nios_start_qbert` restores `lives`=3 and `game_over`=0.
- Chained valid moves to row 6, then DOWN_LEFT → `bad_jump`=1; UP_RIGHT from (6,6) → `bad_jump`=1; UP_RIGHT from (6,5) → valid, lands at (5,5).
- Glitch pulse shorter than DEBOUNCE_CYCLES → no command. Two buttons pressed together → no command. Press during MOVING → ignored.
- Assert `reset`, then separately `nios_start_qbert`, mid-MOVING → next cycle all outputs at reset values and FSM in IDLE.
